tone_map_unit: RTL
==================

Name: tone_map_unit

Overview:
- Parametrised successor to the signal-segment QPSK tone mapper, for the data segment.
- Groups a serial channel-coded bit stream into constellation indices for BPSK, QPSK, 16QAM or 64QAM, selected per OFDM symbol.
- Counts emitted sub-carriers and flags the last tone of each OFDM symbol, so downstream scrambling and IFFT framing can realign.
- Sits between the channel encoder/interleaver and the constellation mapper.

Parameters:
- N_SC, 480: data sub-carriers per OFDM symbol.
- MAX_BITS, 6: maximum bits per tone (64QAM); sets the width of `do`.
- SC_W, 9: sub-carrier counter width; must satisfy 2^SC_W >= N_SC.

Ports:
- clk  in  1  working clock.
- rst  in  1  reset, asynchronous, active high.
- di  in  1  serial input bit.
- di_vld  in  1  `di` valid.
- mode  in  2  modulation select: 0 = BPSK (k=1), 1 = QPSK (k=2), 2 = 16QAM (k=4), 3 = 64QAM (k=6).
- flush  in  1  one-cycle pulse; zero-pads and emits any partial group.
- do  out  MAX_BITS  tone index; bits [k-1:0] are valid, upper bits are 0.
- do_vld  out  1  `do` valid, one-cycle pulse per tone.
- do_last  out  1  qualifies `do_vld`; marks the final tone (index N_SC-1) of a symbol.
- sc_idx  out  SC_W  sub-carrier index of the current `do`, 0..N_SC-1.

Behaviour:
- Reset: `do`, `do_vld`, `do_last`, `sc_idx`, bit counter, sub-carrier counter and latched mode are all cleared to 0. Latched mode resets to BPSK.
- Mode latching:
  - `mode` is sampled only on an accepted bit (`di_vld`=1) when bit_cnt==0 and sc_cnt==0, i.e. the first bit of a symbol.
  - Changes to `mode` at any other time are ignored until the next symbol starts.
  - A bit accepted at the symbol start uses the newly sampled mode.
- Grouping:
  - bit_cnt counts accepted bits 0..k-1.
  - The first accepted bit goes to LSB: `do` = {b(k-1),...,b1,b0}.
  - When `di_vld`=0, bit_cnt and the partial group hold. There is no reset on a gap, so gaps of any length are transparent.
- Output timing:
  - On the clock edge that accepts bit k-1, the registered outputs update: `do` = group, `do_vld`=1.
  - Latency is one cycle after the last bit is presented.
  - `do_vld` deasserts on the next edge unless another group completes. With BPSK and continuous input, `do_vld` is high every cycle.
- Sub-carrier counting:
  - `sc_idx` = sc_cnt value at emission; sc_cnt increments after each emitted tone.
  - At N_SC-1, `do_last`=1 and sc_cnt wraps to 0.
- Flush:
  - Flush with bit_cnt>0 emits the partial group on the next edge: remaining upper bits are 0, `do_vld`=1, normal `sc_idx`/`do_last` handling. bit_cnt then clears.
  - Flush and `di_vld` in the same cycle: `di` is accepted first, then padding is applied. If that bit completes the group, it is emitted normally with no extra tone.
  - Flush with bit_cnt==0 and no accepted bit has no effect.
  - Flush does not reset sc_cnt.
- Reset asserted mid-group or mid-symbol: the partial group is discarded and no output pulse occurs.
- No backpressure: the downstream block must accept one tone per cycle.

Test Plan:
1. QPSK, continuous bits 1,0,1,1 → `do`=2'b01 (6'd1) one cycle after the 2nd bit, then 6'd3 two cycles later. `do_vld` pulses every 2nd cycle; `sc_idx` = 0, then 1.
2. 64QAM, bits 1,1,0,0,0,1 with 3 idle cycles of `di_vld`=0 after the 2nd bit → single `do`=6'b100011 (35) one cycle after the 6th bit; no pulse during the gap.
3. 16QAM, 1920 continuous bits → 480 tones. `do_last`=1 only with `sc_idx`=479; the next tone has `sc_idx`=0.
4. `mode` switches from 1 to 2 at bit 100 of a QPSK symbol → grouping stays at 2 bits until `sc_idx` wraps. The first tone of the next symbol uses 4 bits.
5. 64QAM, 3 bits (1,0,1) then flush → `do`=6'd5 next cycle. Flush concurrent with the 6th bit gives exactly one tone. Flush with an empty group gives no `do_vld`.
6. `rst` pulsed after 3 bits of a 16QAM group → no `do_vld`; all outputs 0; the next symbol restarts at `sc_idx`=0 with the newly sampled mode.

Source files
------------

// File: rtl/tone_map_if.sv
// Tone mapper bit-stream and tone-output bundle.
// The tone index is named do_data because "do" is a reserved keyword.
interface tone_map_if #(
   parameter int unsigned MAX_BITS = 6,
   parameter int unsigned SC_W     = 9
);
   logic                di;
   logic                di_vld;
   logic [1:0]          mode;
   logic                flush;
   logic [MAX_BITS-1:0] do_data;
   logic                do_vld;
   logic                do_last;
   logic [SC_W-1:0]     sc_idx;

   // Upstream encoder/interleaver side
   modport master (
      output di, di_vld, mode, flush,
      input  do_data, do_vld, do_last, sc_idx
   );

   // Tone mapper side
   modport slave (
      input  di, di_vld, mode, flush,
      output do_data, do_vld, do_last, sc_idx
   );
endinterface

// File: rtl/tone_map_unit.sv
// Groups serial coded bits into BPSK/QPSK/16QAM/64QAM tone indices and
// tracks the sub-carrier position within each OFDM symbol.
module tone_map_unit #(
   parameter int unsigned N_SC     = 480,
   parameter int unsigned MAX_BITS = 6,
   parameter int unsigned SC_W     = 9
) (
   input  logic        clk,
   input  logic        rst,
   tone_map_if.slave   bus
);
   localparam int unsigned BC_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

   logic [BC_W-1:0]     bit_cnt;
   logic [BC_W-1:0]     bit_cnt_nxt;
   logic [BC_W-1:0]     last_pos;
   logic [MAX_BITS-1:0] group;
   logic [MAX_BITS-1:0] group_nxt;
   logic [1:0]          mode_q;
   logic [1:0]          mode_eff;
   logic [SC_W-1:0]     sc_cnt;
   logic                sym_start;
   logic                emit;

   // Mode selection, bit accumulation and tone-emission decision
   always_comb begin
      sym_start   = bus.di_vld && (bit_cnt == '0) && (sc_cnt == '0);
      mode_eff    = sym_start ? bus.mode : mode_q;
      last_pos    = BC_W'(0);
      group_nxt   = group;
      bit_cnt_nxt = bit_cnt;
      case (mode_eff)
         2'd0:    last_pos = BC_W'(0);
         2'd1:    last_pos = BC_W'(1);
         2'd2:    last_pos = BC_W'(3);
         default: last_pos = BC_W'(MAX_BITS - 1);
      endcase
      if (bus.di_vld) begin
         group_nxt   = group | (MAX_BITS'(bus.di) << bit_cnt);
         bit_cnt_nxt = bit_cnt + BC_W'(1);
      end
      // A flush pads whatever is held, including a bit accepted this cycle
      emit = (bus.di_vld && (bit_cnt == last_pos)) ||
             (bus.flush && (bus.di_vld || (bit_cnt != '0)));
   end

   // Group, counter and registered output state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         group       <= '0;
         mode_q      <= '0;
         sc_cnt      <= '0;
         bus.do_data <= '0;
         bus.do_vld  <= 1'b0;
         bus.do_last <= 1'b0;
         bus.sc_idx  <= '0;
      end else begin
         mode_q      <= mode_eff;
         bus.do_vld  <= emit;
         bus.do_last <= emit && (sc_cnt == SC_W'(N_SC - 1));
         if (emit) begin
            bus.do_data <= group_nxt;
            bus.sc_idx  <= sc_cnt;
            sc_cnt      <= (sc_cnt == SC_W'(N_SC - 1)) ? '0 : sc_cnt + SC_W'(1);
            bit_cnt     <= '0;
            group       <= '0;
         end else begin
            bit_cnt     <= bit_cnt_nxt;
            group       <= group_nxt;
         end
      end
   end
endmodule
